// File: rtl/spi_flash_emu.sv
// SPI-flash slave emulator (mode 0): READ, FAST_READ and JEDEC ID
// served from a preloadable word RAM, SPI pins oversampled on clk.
module spi_flash_emu #(
  parameter int          ADDR_BITS    = 24,
  parameter int          DEPTH        = 1096,
  parameter int          DUMMY_CYCLES = 8,
  parameter logic [23:0] JEDEC_ID     = 24'hEF4016
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     spi_cs_n,
  input  logic                     spi_sclk,
  input  logic                     spi_mosi,
  output logic                     spi_miso,
  output logic                     spi_miso_oe,
  input  logic                     ld_we,
  input  logic [$clog2(DEPTH)-1:0] ld_addr,
  input  logic [31:0]              ld_data,
  output logic                     busy,
  output logic                     cmd_err,
  output logic [15:0]              rd_bytes
);

  localparam int BYTES = 4 * DEPTH;
  localparam int BA    = $clog2(BYTES);
  localparam int WA    = $clog2(DEPTH);
  localparam int CM0   = (ADDR_BITS > 24) ? ADDR_BITS : 24;
  localparam int CMAX  = (DUMMY_CYCLES > CM0) ? DUMMY_CYCLES : CM0;
  localparam int CW    = $clog2(CMAX + 1);

  localparam logic [CW-1:0] C_CMD  = CW'(7);
  localparam logic [CW-1:0] C_ADR  = CW'(ADDR_BITS - 1);
  localparam logic [CW-1:0] C_DUM  =
    CW'((DUMMY_CYCLES == 0) ? 0 : DUMMY_CYCLES - 1);
  localparam logic [CW-1:0] C_BYTE = CW'(7);
  localparam logic [CW-1:0] C_ID   = CW'(23);

  typedef enum logic [2:0] {
    IDLE,
    CMD,
    ADDR,
    DUMMY,
    DATA,
    ID,
    IGNORE
  } state_t;

  state_t               state;
  logic [1:0]           cs_sy;
  logic [2:0]           sck_sy;
  logic [1:0]           mosi_sy;
  logic [ADDR_BITS-1:0] sh;
  logic [CW-1:0]        cnt;
  logic                 fast;
  logic [BA-1:0]        byte_addr;
  logic [31:0]          ram_q;
  logic [23:0]          tx;
  logic [31:0]          mem [DEPTH];

  logic                 cs_s;
  logic                 rise;
  logic                 fall;
  logic                 mosi_s;
  logic                 ld_ok;
  logic [ADDR_BITS-1:0] a_full;
  logic [ADDR_BITS-1:0] a_mod;
  logic [BA-1:0]        a_in;
  logic [BA-1:0]        a_nxt;
  logic [WA-1:0]        rd_idx;
  logic [31:0]          rd_word;
  logic [7:0]           cmd_b;
  logic [7:0]           cur_byte;

  assign cs_s   = cs_sy[1];
  assign rise   = sck_sy[1] & ~sck_sy[2];
  assign fall   = ~sck_sy[1] & sck_sy[2];
  assign mosi_s = mosi_sy[1];
  assign ld_ok  = {1'b0, ld_addr} < (WA + 1)'(DEPTH);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cs_sy   <= '1;
      sck_sy  <= '0;
      mosi_sy <= '0;
    end else begin
      cs_sy   <= {cs_sy[0], spi_cs_n};
      sck_sy  <= {sck_sy[1:0], spi_sclk};
      mosi_sy <= {mosi_sy[0], spi_mosi};
    end
  end

  always_ff @(posedge clk) begin
    if (ld_we && ld_ok) mem[ld_addr] <= ld_data;
  end

  // Reads bypass a same-clk preload so a fetch never returns stale data.
  always_comb begin
    a_full   = {sh[ADDR_BITS-2:0], mosi_s};
    a_mod    = a_full % ADDR_BITS'(BYTES);
    a_in     = a_mod[BA-1:0];
    cmd_b    = a_full[7:0];
    a_nxt    = (byte_addr == BA'(BYTES - 1)) ? '0 : byte_addr + BA'(1);
    rd_idx   = (state == ADDR) ? a_in[BA-1:2] : a_nxt[BA-1:2];
    rd_word  = (ld_we && ld_ok && ld_addr == rd_idx) ? ld_data : mem[rd_idx];
    cur_byte = ram_q[{byte_addr[1:0], 3'b000} +: 8];
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      sh          <= '0;
      cnt         <= '0;
      fast        <= 1'b0;
      byte_addr   <= '0;
      ram_q       <= '0;
      tx          <= '0;
      spi_miso    <= 1'b1;
      spi_miso_oe <= 1'b0;
      busy        <= 1'b0;
      cmd_err     <= 1'b0;
      rd_bytes    <= '0;
    end else begin
      cmd_err <= 1'b0;
      if (cs_s) begin
        state       <= IDLE;
        sh          <= '0;
        cnt         <= '0;
        tx          <= '0;
        spi_miso    <= 1'b1;
        spi_miso_oe <= 1'b0;
        busy        <= 1'b0;
      end else begin
        unique case (state)
          IDLE: begin
            state <= CMD;
            busy  <= 1'b1;
            sh    <= '0;
            cnt   <= '0;
          end
          CMD: begin
            if (rise) begin
              sh  <= a_full;
              cnt <= cnt + CW'(1);
              if (cnt == C_CMD) begin
                cnt <= '0;
                sh  <= '0;
                unique case (1'b1)
                  cmd_b == 8'h03: begin
                    state <= ADDR;
                    fast  <= 1'b0;
                  end
                  cmd_b == 8'h0B: begin
                    state <= ADDR;
                    fast  <= 1'b1;
                  end
                  cmd_b == 8'h9F: state <= ID;
                  default: begin
                    state   <= IGNORE;
                    cmd_err <= 1'b1;
                  end
                endcase
              end
            end
          end
          ADDR: begin
            if (rise) begin
              sh  <= a_full;
              cnt <= cnt + CW'(1);
              if (cnt == C_ADR) begin
                cnt       <= '0;
                byte_addr <= a_in;
                ram_q     <= rd_word;
                state     <= (fast && DUMMY_CYCLES != 0) ? DUMMY : DATA;
              end
            end
          end
          DUMMY: begin
            if (rise) begin
              cnt <= cnt + CW'(1);
              if (cnt == C_DUM) begin
                cnt   <= '0;
                state <= DATA;
              end
            end
          end
          DATA: begin
            if (rise) begin
              if (cnt == C_BYTE) begin
                cnt       <= '0;
                byte_addr <= a_nxt;
                ram_q     <= rd_word;
                if (rd_bytes != 16'hFFFF) rd_bytes <= rd_bytes + 16'd1;
              end else begin
                cnt <= cnt + CW'(1);
              end
            end else if (fall) begin
              spi_miso_oe <= 1'b1;
              if (cnt == '0) begin
                spi_miso <= cur_byte[7];
                tx       <= {cur_byte[6:0], 17'b0};
              end else begin
                spi_miso <= tx[23];
                tx       <= {tx[22:0], 1'b0};
              end
            end
          end
          ID: begin
            if (rise) begin
              cnt <= (cnt == C_ID) ? '0 : cnt + CW'(1);
            end else if (fall) begin
              spi_miso_oe <= 1'b1;
              if (cnt == '0) begin
                spi_miso <= JEDEC_ID[23];
                tx       <= {JEDEC_ID[22:0], 1'b0};
              end else begin
                spi_miso <= tx[23];
                tx       <= {tx[22:0], 1'b0};
              end
            end
          end
          IGNORE: ;
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_spi_flash_emu.sv
// Bench for spi_flash_emu: table of flash transactions plus hand
// sequences for bad command, deselect mid-address and async reset.
module tb_spi_flash_emu;

  localparam int HP = 60;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        cs0 = 1'b1;
  logic        cs1 = 1'b1;
  logic        sclk = 1'b0;
  logic        mosi = 1'b0;
  logic        miso0, oe0, busy0, err0;
  logic        miso1, oe1, busy1, err1;
  logic [15:0] rdb0, rdb1;
  logic        ld_we0 = 1'b0;
  logic        ld_we1 = 1'b0;
  logic [10:0] ld_addr0 = '0;
  logic [1:0]  ld_addr1 = '0;
  logic [31:0] ld_data = '0;

  int checks = 0;
  int errors = 0;
  int err_pulses = 0;
  int oe_clks = 0;
  logic [7:0] exp_q[$];

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (err0) err_pulses <= err_pulses + 1;
    if (oe0) oe_clks <= oe_clks + 1;
  end

  spi_flash_emu dut0 (
    .clk(clk), .reset(reset), .spi_cs_n(cs0), .spi_sclk(sclk),
    .spi_mosi(mosi), .spi_miso(miso0), .spi_miso_oe(oe0),
    .ld_we(ld_we0), .ld_addr(ld_addr0), .ld_data(ld_data),
    .busy(busy0), .cmd_err(err0), .rd_bytes(rdb0)
  );

  spi_flash_emu #(.DEPTH(4)) dut1 (
    .clk(clk), .reset(reset), .spi_cs_n(cs1), .spi_sclk(sclk),
    .spi_mosi(mosi), .spi_miso(miso1), .spi_miso_oe(oe1),
    .ld_we(ld_we1), .ld_addr(ld_addr1), .ld_data(ld_data),
    .busy(busy1), .cmd_err(err1), .rd_bytes(rdb1)
  );

  typedef struct {
    int          sel;
    logic [7:0]  cmd;
    logic [23:0] addr;
    bit          has_addr;
    int          ndum;
    int          n;
    logic [63:0] exp;
    int          rdb;
  } vec_t;

  vec_t vt[5];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  task automatic preload(input int sel, input int a, input logic [31:0] d);
    @(negedge clk);
    ld_data = d;
    if (sel == 1) begin
      ld_addr1 = a[1:0];
      ld_we1 = 1'b1;
    end else begin
      ld_addr0 = a[10:0];
      ld_we0 = 1'b1;
    end
    @(negedge clk);
    ld_we0 = 1'b0;
    ld_we1 = 1'b0;
  endtask

  task automatic cs_set(input int sel, input logic v);
    if (sel == 1) cs1 = v;
    else cs0 = v;
  endtask

  task automatic sbit(input int sel, input logic b,
                      output logic r, output logic o);
    mosi = b;
    #HP;
    sclk = 1'b1;
    r = (sel == 1) ? miso1 : miso0;
    o = (sel == 1) ? oe1 : oe0;
    #HP;
    sclk = 1'b0;
  endtask

  task automatic send_bits(input int sel, input logic [31:0] v, input int nb);
    logic r, o;
    for (int i = nb - 1; i >= 0; i--) sbit(sel, v[i], r, o);
  endtask

  task automatic dummy(input int sel, input int n, output logic oe_any);
    logic r, o;
    oe_any = 1'b0;
    for (int i = 0; i < n; i++) begin
      sbit(sel, 1'b0, r, o);
      if (o) oe_any = 1'b1;
    end
  endtask

  task automatic recv(input int sel, input int n, output logic oe_all);
    logic r, o;
    logic [7:0] b, e;
    oe_all = 1'b1;
    for (int k = 0; k < n; k++) begin
      b = '0;
      for (int i = 7; i >= 0; i--) begin
        sbit(sel, 1'b0, r, o);
        b[i] = r;
        if (o !== 1'b1) oe_all = 1'b0;
      end
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL sb_empty actual=%h required=none", b);
      end else begin
        e = exp_q.pop_front();
        chk($sformatf("byte%0d_dut%0d", k, sel), 32'(b), 32'(e));
      end
    end
  endtask

  task automatic xact(input int sel, input logic [7:0] cmd,
                      input logic [23:0] addr, input bit has_addr,
                      input int ndum, input int n);
    logic oa;
    cs_set(sel, 1'b0);
    #HP;
    send_bits(sel, 32'(cmd), 8);
    chk("busy", 32'((sel == 1) ? busy1 : busy0), 32'd1);
    if (has_addr) send_bits(sel, 32'(addr), 24);
    if (ndum > 0) begin
      dummy(sel, ndum, oa);
      chk("dummy_oe", 32'(oa), 32'd0);
    end
    if (n > 0) begin
      recv(sel, n, oa);
      chk("data_oe", 32'(oa), 32'd1);
    end
    cs_set(sel, 1'b1);
    #(HP * 2);
    chk("cs_oe_off", 32'((sel == 1) ? oe1 : oe0), 32'd0);
    chk("cs_busy_off", 32'((sel == 1) ? busy1 : busy0), 32'd0);
  endtask

  task automatic push_bytes(input logic [63:0] v, input int n);
    logic [63:0] t;
    t = v;
    for (int i = 0; i < n; i++) begin
      exp_q.push_back(t[63:56]);
      t = t << 8;
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int eb, ob;
    logic oa;
    vt[0] = '{0, 8'h03, 24'h000000, 1'b1, 0, 8, 64'h1301018013000000, 8};
    vt[1] = '{0, 8'h0B, 24'h000002, 1'b1, 8, 3, 64'h0180130000000000, 11};
    vt[2] = '{0, 8'h9F, 24'h000000, 1'b0, 0, 6, 64'hEF4016EF40160000, 11};
    vt[3] = '{0, 8'h03, 24'h000003, 1'b1, 0, 2, 64'h8013000000000000, 13};
    vt[4] = '{1, 8'h03, 24'h00000E, 1'b1, 0, 4, 64'hCCDD112200000000, 4};

    #20;
    chk("rst_miso", 32'(miso0), 32'd1);
    chk("rst_oe", 32'(oe0), 32'd0);
    chk("rst_busy", 32'(busy0), 32'd0);
    chk("rst_cmd_err", 32'(err0), 32'd0);
    chk("rst_rd_bytes", 32'(rdb0), 32'd0);
    @(negedge clk);
    reset = 1'b1;

    preload(0, 0, 32'h80010113);
    preload(0, 1, 32'h00000013);
    preload(1, 3, 32'hDDCCBBAA);
    preload(1, 0, 32'h44332211);
    #(HP * 2);

    eb = err_pulses;
    for (int v = 0; v < 5; v++) begin
      push_bytes(vt[v].exp, vt[v].n);
      xact(vt[v].sel, vt[v].cmd, vt[v].addr, vt[v].has_addr,
           vt[v].ndum, vt[v].n);
      chk($sformatf("rd_bytes_v%0d", v),
          32'((vt[v].sel == 1) ? rdb1 : rdb0), 32'(vt[v].rdb));
    end
    chk("no_cmd_err", 32'(err_pulses - eb), 32'd0);

    eb = err_pulses;
    ob = oe_clks;
    xact(0, 8'h5A, 24'h0, 1'b0, 16, 0);
    chk("cmd_err_pulses", 32'(err_pulses - eb), 32'd1);
    chk("bad_cmd_oe_clks", 32'(oe_clks - ob), 32'd0);
    push_bytes(64'h1300000000000000, 1);
    xact(0, 8'h03, 24'h000004, 1'b1, 0, 1);
    chk("rd_bytes_recover", 32'(rdb0), 32'd14);

    cs0 = 1'b0;
    #HP;
    send_bits(0, 32'h03, 8);
    send_bits(0, 32'h0, 13);
    cs0 = 1'b1;
    #(HP * 2);
    chk("abort_oe", 32'(oe0), 32'd0);
    push_bytes(64'h1301000000000000, 2);
    xact(0, 8'h03, 24'h000000, 1'b1, 0, 2);
    chk("rd_bytes_abort", 32'(rdb0), 32'd16);

    cs0 = 1'b0;
    #HP;
    send_bits(0, 32'h03, 8);
    send_bits(0, 32'h0, 24);
    push_bytes(64'h1301000000000000, 2);
    recv(0, 2, oa);
    chk("pre_rst_oe", 32'(oa), 32'd1);
    reset = 1'b0;
    #1;
    chk("arst_miso", 32'(miso0), 32'd1);
    chk("arst_oe", 32'(oe0), 32'd0);
    chk("arst_busy", 32'(busy0), 32'd0);
    chk("arst_cmd_err", 32'(err0), 32'd0);
    chk("arst_rd_bytes", 32'(rdb0), 32'd0);
    cs0 = 1'b1;
    #9;
    #HP;
    reset = 1'b1;
    #(HP * 2);
    push_bytes(64'h1300000000000000, 1);
    xact(0, 8'h03, 24'h000000, 1'b1, 0, 1);
    chk("rd_bytes_post_rst", 32'(rdb0), 32'd1);
    chk("sb_drained", 32'(exp_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
